// File: rtl/lz_match_search.sv
// lz_match_search
// Serial LZ77 longest-match engine. On a start pulse it latches the cursor
// (win_base) and the lookahead, then compares the window RAM against the
// lookahead one symbol at a time, for each candidate position p = 0..63.
// It reports one token: a match (offset, length) or a literal (symbol 0).
// A match never runs past window position WIN_DEPTH-1.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle search request, accepted only in IDLE
//   win_base        RAM address of window position 0
//   la_data         lookahead, symbol k at [k*DW +: DW]
//   la_valid_len    number of valid lookahead symbols (0..LA_LEN)
//   rd_en, rd_addr  window RAM read strobe/address
//   rd_data         RAM data, valid the cycle after rd_en
//   busy            search in progress
//   token_valid     token available, held stable until token_ready
//   token_ready     downstream accepts the token
//   is_match, best_offset, best_len, literal   token fields
//   done            one-cycle pulse once the token is consumed
//
// state | meaning
// IDLE  | waiting for start
// RD    | issue read of window position p+k
// CMP   | compare returned symbol with lookahead symbol k
// EMIT  | token presented, waiting for token_ready
// DONE  | one-cycle done pulse
module lz_match_search #(
    parameter int WIN_DEPTH = 64,
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int LA_LEN    = 8,
    parameter int LW        = 4,
    parameter int MIN_MATCH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        win_base,
    input  logic [LA_LEN*DW-1:0] la_data,
    input  logic [LW-1:0]        la_valid_len,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [DW-1:0]        rd_data,
    output logic                 busy,
    output logic                 token_valid,
    input  logic                 token_ready,
    output logic                 is_match,
    output logic [AW-1:0]        best_offset,
    output logic [LW-1:0]        best_len,
    output logic [DW-1:0]        literal,
    output logic                 done
);

    localparam int KW = $clog2(LA_LEN);
    localparam logic [AW:0]   WIN_END = (AW+1)'(WIN_DEPTH);
    localparam logic [AW-1:0] P_LAST  = AW'(WIN_DEPTH - 1);
    localparam logic [LW-1:0] MIN_LEN = LW'(MIN_MATCH);

    typedef enum logic [2:0] {IDLE, RD, CMP, EMIT, DONE} state_t;

    state_t                state, state_nx;
    logic [AW-1:0]         base_q, base_nx;
    logic [LA_LEN*DW-1:0]  la_q, la_nx;
    logic [LW-1:0]         len_q, len_nx;
    logic [AW-1:0]         p_q, p_nx;
    logic [LW-1:0]         k_q, k_nx;
    logic [LW-1:0]         bl_q, bl_nx;
    logic [AW-1:0]         bo_q, bo_nx;

    logic [DW-1:0] la_sym [LA_LEN];
    logic          eq;
    logic [LW:0]   k_inc;
    logic [AW:0]   pk_inc;
    logic [LW-1:0] cand;
    logic [LW-1:0] new_bl;
    logic          long_enough;

    for (genvar i = 0; i < LA_LEN; i++) begin : g_sym
        assign la_sym[i] = la_q[i*DW +: DW];
    end

    assign eq          = (rd_data == la_sym[k_q[KW-1:0]]);
    assign k_inc       = {1'b0, k_q} + (LW+1)'(1);
    // position of the next symbol in the window; must stay below WIN_DEPTH
    assign pk_inc      = {1'b0, p_q} + (AW+1)'(k_q) + (AW+1)'(1);
    assign cand        = k_q + LW'(eq);
    // strictly greater keeps the earliest position on ties
    assign new_bl      = (cand > bl_q) ? cand : bl_q;
    assign long_enough = (bl_q >= MIN_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
            la_q   <= '0;
            len_q  <= '0;
            p_q    <= '0;
            k_q    <= '0;
            bl_q   <= '0;
            bo_q   <= '0;
        end else begin
            state  <= state_nx;
            base_q <= base_nx;
            la_q   <= la_nx;
            len_q  <= len_nx;
            p_q    <= p_nx;
            k_q    <= k_nx;
            bl_q   <= bl_nx;
            bo_q   <= bo_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        base_nx     = base_q;
        la_nx       = la_q;
        len_nx      = len_q;
        p_nx        = p_q;
        k_nx        = k_q;
        bl_nx       = bl_q;
        bo_nx       = bo_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        busy        = 1'b0;
        token_valid = 1'b0;
        is_match    = 1'b0;
        best_offset = '0;
        best_len    = '0;
        literal     = '0;
        done        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    base_nx  = win_base;
                    la_nx    = la_data;
                    len_nx   = la_valid_len;
                    p_nx     = '0;
                    k_nx     = '0;
                    bl_nx    = '0;
                    bo_nx    = '0;
                    state_nx = (la_valid_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                // modulo-2^AW add gives the circular RAM wrap
                rd_addr  = base_q + p_q + AW'(k_q);
                state_nx = CMP;
            end
            CMP: begin
                busy = 1'b1;
                if (eq && (k_inc < {1'b0, len_q}) && (pk_inc < WIN_END)) begin
                    k_nx     = k_inc[LW-1:0];
                    state_nx = RD;
                end else begin
                    if (cand > bl_q) begin
                        bl_nx = cand;
                        bo_nx = p_q;
                    end
                    if ((new_bl == len_q) || (p_q == P_LAST)) begin
                        state_nx = EMIT;
                    end else begin
                        p_nx     = p_q + AW'(1);
                        k_nx     = '0;
                        state_nx = RD;
                    end
                end
            end
            EMIT: begin
                busy        = 1'b1;
                token_valid = 1'b1;
                is_match    = long_enough;
                best_offset = long_enough ? bo_q : '0;
                best_len    = long_enough ? bl_q : LW'(1);
                literal     = la_sym[0];
                if (token_ready) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lz_match_search.sv
module tb_lz_match_search;
    localparam int AW = 6, DW = 8, LA_LEN = 8, LW = 4, WD = 64;

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, token_ready = 1'b0;
    logic [AW-1:0] win_base = '0;
    logic [63:0]   la_data = '0;
    logic [LW-1:0] la_valid_len = '0;
    logic          rd_en, busy, token_valid, is_match, done;
    logic [AW-1:0] rd_addr, best_offset;
    logic [LW-1:0] best_len;
    logic [DW-1:0] rd_data, literal;

    lz_match_search #(.WIN_DEPTH(WD), .AW(AW), .DW(DW), .LA_LEN(LA_LEN), .LW(LW), .MIN_MATCH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_base(win_base), .la_data(la_data),
        .la_valid_len(la_valid_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .token_valid(token_valid), .token_ready(token_ready), .is_match(is_match),
        .best_offset(best_offset), .best_len(best_len), .literal(literal), .done(done));

    always #5 clk = ~clk;

    logic [7:0] mem [WD];
    int rd_q[$];
    int exp_addr[$];
    int total = 0, bad = 0;

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_data <= mem[rd_addr];
            rd_q.push_back(int'(rd_addr));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // window: ramp 0x00..0x3F, then lookahead prefixes planted at window positions
    task automatic prep(input int base, input logic [63:0] la, input int pos1, input int len1,
                        input int pos2, input int len2);
        for (int i = 0; i < WD; i++) mem[i] = 8'(i);
        for (int q = 0; q < len1; q++) mem[(base + pos1 + q) % WD] = la[q*8 +: 8];
        for (int q = 0; q < len2; q++) mem[(base + pos2 + q) % WD] = la[q*8 +: 8];
    endtask

    // reference: scan every candidate, longest earliest match, truncated at window end
    task automatic model(input int base, input int len, input logic [63:0] la,
                         output bit mm, output int off, output int bl, output int cyc);
        int best = 0, boff = 0, tot = 0;
        exp_addr.delete();
        if (len > 0) begin
            for (int p = 0; p < WD; p++) begin
                int lim = (len < WD - p) ? len : WD - p;
                int rl = 0, nc;
                while (rl < lim && mem[(base + p + rl) % WD] == la[rl*8 +: 8]) rl++;
                nc = (rl < lim) ? rl + 1 : lim;
                for (int k = 0; k < nc; k++) exp_addr.push_back((base + p + k) % WD);
                tot += nc;
                if (rl > best) begin best = rl; boff = p; end
                if (best == len) break;
            end
        end
        mm  = (best >= 2);
        off = mm ? boff : 0;
        bl  = mm ? best : 1;
        cyc = 2 * tot;
    endtask

    task automatic run_one(input string nm, input int base, input int len, input logic [63:0] la,
                           input int delay, input bit e_match, input int e_off, input int e_len,
                           input int e_cyc);
        bit mm; int mo, ml, mc, cyc, diff;
        bit stable, any_done;
        model(base, len, la, mm, mo, ml, mc);
        rd_q.delete();
        @(negedge clk);
        win_base = AW'(base); la_data = la; la_valid_len = LW'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        if (len == 0) begin
            chk({nm, ".done0"}, done, 1);
            chk({nm, ".tv0"}, token_valid, 0);
            @(posedge clk); #1;
            chk({nm, ".idle0"}, {done, busy, rd_en}, 0);
            chk({nm, ".nord"}, rd_q.size(), 0);
            return;
        end
        while (token_valid !== 1'b1 && cyc < 1200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, ".cyc"}, cyc, e_cyc);
        chk({nm, ".is_match"}, is_match, e_match);
        chk({nm, ".offset"}, best_offset, e_off);
        chk({nm, ".len"}, best_len, e_len);
        chk({nm, ".literal"}, literal, la[7:0]);
        chk({nm, ".busy"}, busy, 1);
        stable = 1'b1; any_done = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            if (token_valid !== 1'b1 || is_match !== e_match || best_offset !== AW'(e_off) ||
                best_len !== LW'(e_len) || literal !== la[7:0]) stable = 1'b0;
            if (done !== 1'b0) any_done = 1'b1;
        end
        chk({nm, ".hold"}, {stable, any_done}, 2'b10);
        token_ready = 1'b1;
        @(posedge clk); #1;
        token_ready = 1'b0;
        chk({nm, ".done"}, {done, token_valid, busy}, 3'b100);
        @(posedge clk); #1;
        chk({nm, ".after"}, {done, busy}, 0);
        diff = -1;
        for (int i = 0; i < rd_q.size() || i < exp_addr.size(); i++) begin
            if (i >= rd_q.size() || i >= exp_addr.size() || rd_q[i] != exp_addr[i]) begin
                diff = i;
                break;
            end
        end
        chk({nm, ".rdseq_first_bad_index"}, diff, -1);
    endtask

    typedef struct {
        string nm; int base; int len; logic [63:0] la;
        int pos1; int len1; int pos2; int len2; int delay;
        bit e_match; int e_off; int e_len; int e_cyc;
    } vec_t;

    localparam logic [63:0] LA1 = 64'hACAB_AAA9_A8A7_A6A5;

    vec_t tv [8];
    bit   mm;
    int   mo, ml, mc, cyc;
    logic [63:0] la;

    initial begin
        tv[0] = '{"literal", 0, 8, LA1, 0, 0, 0, 0, 0, 1'b0, 0, 1, 128};
        tv[1] = '{"full",    0, 8, LA1, 5, 8, 0, 0, 10, 1'b1, 5, 8, 26};
        tv[2] = '{"tie",     0, 6, LA1, 3, 4, 10, 4, 1, 1'b1, 3, 4, 144};
        tv[3] = '{"wrap",   60, 8, LA1, 2, 8, 0, 0, 0, 1'b1, 2, 8, 20};
        tv[4] = '{"winend",  0, 8, LA1, 62, 3, 0, 0, 2, 1'b1, 62, 2, 130};
        tv[5] = '{"len0",    0, 0, LA1, 0, 0, 0, 0, 0, 1'b0, 0, 1, 0};
        tv[6] = '{"len1",    0, 1, LA1, 7, 1, 0, 0, 0, 1'b0, 0, 1, 16};
        tv[7] = '{"end2",    0, 2, LA1, 63, 2, 0, 0, 0, 1'b0, 0, 1, 128};

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset.outputs", {rd_en, rd_addr, busy, token_valid, is_match, best_offset,
                              best_len, literal, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.idle", {busy, rd_en, done}, 0);

        for (int i = 0; i < 8; i++) begin
            prep(tv[i].base, tv[i].la, tv[i].pos1, tv[i].len1, tv[i].pos2, tv[i].len2);
            run_one(tv[i].nm, tv[i].base, tv[i].len, tv[i].la, tv[i].delay,
                    tv[i].e_match, tv[i].e_off, tv[i].e_len, tv[i].e_cyc);
        end

        // start while busy is ignored, then start during DONE is ignored
        prep(0, LA1, 5, 8, 0, 0);
        @(negedge clk);
        win_base = '0; la_data = LA1; la_valid_len = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; win_base = 6'd20; la_data = '1; la_valid_len = 4'd3;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (token_valid !== 1'b1 && cyc < 1200) begin @(posedge clk); #1; cyc++; end
        chk("busy_start.cyc", cyc, 26);
        chk("busy_start.token", {is_match, best_offset, best_len}, {1'b1, 6'd5, 4'd8});
        token_ready = 1'b1;
        @(posedge clk); #1;
        token_ready = 1'b0;
        chk("busy_start.done", done, 1);
        win_base = '0; la_data = LA1; la_valid_len = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_start.ignored", {busy, rd_en}, 0);
        @(posedge clk); #1;
        chk("done_start.still_idle", {busy, rd_en}, 0);

        // reset in the middle of a search
        prep(0, LA1, 0, 0, 0, 0);
        @(negedge clk);
        win_base = '0; la_data = LA1; la_valid_len = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.outputs", {busy, token_valid, rd_en, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen = 1'b0;
            repeat (150) begin
                @(posedge clk); #1;
                if (done !== 1'b0 || token_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            end
            chk("midreset.quiet", seen, 0);
        end
        run_one("after_reset", 0, 8, LA1, 0, 1'b0, 0, 1, 128);

        // randomized windows over a two-symbol alphabet, checked against the model
        for (int t = 0; t < 25; t++) begin
            int base = $urandom_range(0, 63);
            int len  = $urandom_range(0, 8);
            for (int i = 0; i < WD; i++) mem[i] = 8'($urandom_range(0, 1));
            la = '0;
            for (int k = 0; k < LA_LEN; k++) la[k*8 +: 8] = 8'($urandom_range(0, 1));
            model(base, len, la, mm, mo, ml, mc);
            run_one($sformatf("rand%0d", t), base, len, la, $urandom_range(0, 3), mm, mo, ml, mc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
